// File: rtl/sp_accum_bank.sv
// ---------------------------------------------------------------------------
// sp_accum_bank
//
// Result scratchpad for the matrix-multiply accelerator. It holds SP_NTARGETS
// matrices of MAX_DIM x MAX_DIM elements. Each line is one BUS_WIDTH row of
// MAX_DIM elements of DATA_WIDTH bits. Line index = {target, addr}.
//
// Ports
//   clk_i, rst_ni      clock and asynchronous active-low reset
//   wr_en_i            write request, accepted when wr_ready_o is high
//   wr_acc_i           1 = accumulate into the element, 0 = overwrite
//   wr_strb_i          per-element write enable (bit k -> element k)
//   wr_target_i        write target
//   wr_addr_i          write line address
//   wr_data_i          write data
//   wr_ready_o         low while a clear sweep is running
//   rd_en_i            read request for both ports
//   rd_target_i        read target
//   rd_addr_a_i        port A line address
//   rd_addr_b_i        port B line address
//   rd_data_a_o        port A data (registered, 1-cycle latency)
//   rd_data_b_o        port B data (registered, 1-cycle latency)
//   rd_valid_o         read data valid
//   clr_i              start a hardware clear of clr_target_i
//   clr_target_i       target to clear
//   busy_o             clear sweep in progress
//   clr_done_o         one-cycle pulse after the last line is cleared
//
// Build option
//   SP_ACC_SAT_EN      when defined, accumulate is signed and saturating.
//                      When it is undefined, accumulate wraps modulo
//                      2^DATA_WIDTH.
// ---------------------------------------------------------------------------
module sp_accum_bank #(
    parameter int  SP_NTARGETS = 4,
    parameter int  DATA_WIDTH  = 32,
    parameter int  BUS_WIDTH   = 64,
    localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
    localparam int AW          = 2 * $clog2(MAX_DIM),
    localparam int TW          = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic                 wr_acc_i,
    input  logic [MAX_DIM-1:0]   wr_strb_i,
    input  logic [TW-1:0]        wr_target_i,
    input  logic [AW-1:0]        wr_addr_i,
    input  logic [BUS_WIDTH-1:0] wr_data_i,
    output logic                 wr_ready_o,
    input  logic                 rd_en_i,
    input  logic [TW-1:0]        rd_target_i,
    input  logic [AW-1:0]        rd_addr_a_i,
    input  logic [AW-1:0]        rd_addr_b_i,
    output logic [BUS_WIDTH-1:0] rd_data_a_o,
    output logic [BUS_WIDTH-1:0] rd_data_b_o,
    output logic                 rd_valid_o,
    input  logic                 clr_i,
    input  logic [TW-1:0]        clr_target_i,
    output logic                 busy_o,
    output logic                 clr_done_o
);

    localparam int              LPT      = MAX_DIM * MAX_DIM;
    localparam int              NLINES   = SP_NTARGETS * LPT;
    localparam int              IW       = TW + AW;
    localparam logic [AW-1:0]   CNT_LAST = AW'(LPT - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    // Accumulate one element. The saturating build treats both operands as
    // signed and uses one guard bit to detect overflow.
    function automatic logic signed [DATA_WIDTH-1:0] acc_elem(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
`ifdef SP_ACC_SAT_EN
        logic signed [DATA_WIDTH:0] sum;
        sum = a + b;
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            return sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return sum[DATA_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    logic [BUS_WIDTH-1:0] mem [NLINES];

    state_t               state_q, state_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]        tgt_q, tgt_d;
    logic                 clr_done_q, clr_done_d;

    logic                 sweep;
    logic                 wr_fire;
    logic [IW-1:0]        wr_idx;
    logic [IW-1:0]        clr_idx;
    logic [IW-1:0]        rd_idx_a;
    logic [IW-1:0]        rd_idx_b;

    logic [BUS_WIDTH-1:0] rd_data_a_p1;
    logic [BUS_WIDTH-1:0] rd_data_b_p1;
    logic                 vld_p1;

    assign sweep      = (state_q == CLEAR);
    assign busy_o     = sweep;
    assign wr_ready_o = ~sweep;
    assign wr_fire    = wr_en_i & ~sweep;
    assign wr_idx     = {wr_target_i, wr_addr_i};
    assign clr_idx    = {tgt_q, cnt_q};
    assign rd_idx_a   = {rd_target_i, rd_addr_a_i};
    assign rd_idx_b   = {rd_target_i, rd_addr_b_i};

    // Clear sweep controller
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tgt_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            clr_done_q <= clr_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    tgt_d   = clr_target_i;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clr_done_o = clr_done_q;

    // Line storage. Writes are refused while sweeping, so the sweep and
    // the write path never touch the array on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NLINES; i++) begin
                mem[i] <= '0;
            end
        end else if (sweep) begin
            mem[clr_idx] <= '0;
        end else if (wr_fire) begin
            for (int k = 0; k < MAX_DIM; k++) begin
                if (wr_strb_i[k]) begin
                    mem[wr_idx][k*DATA_WIDTH +: DATA_WIDTH] <= wr_acc_i
                        ? acc_elem(mem[wr_idx][k*DATA_WIDTH +: DATA_WIDTH],
                                   wr_data_i[k*DATA_WIDTH +: DATA_WIDTH])
                        : wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Read stage p0 -> p1: the read captures the contents before this
    // edge's update, and the data holds when no read is requested.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_a_p1 <= '0;
            rd_data_b_p1 <= '0;
            vld_p1       <= 1'b0;
        end else begin
            vld_p1 <= rd_en_i;
            if (rd_en_i) begin
                rd_data_a_p1 <= mem[rd_idx_a];
                rd_data_b_p1 <= mem[rd_idx_b];
            end
        end
    end

    assign rd_data_a_o = rd_data_a_p1;
    assign rd_data_b_o = rd_data_b_p1;
    assign rd_valid_o  = vld_p1;

endmodule

// File: tb/tb_sp_accum_bank.sv
module tb_sp_accum_bank;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        wr_acc;
    logic [1:0]  wr_strb;
    logic [1:0]  wr_target;
    logic [1:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_ready;
    logic        rd_en;
    logic [1:0]  rd_target;
    logic [1:0]  rd_addr_a;
    logic [1:0]  rd_addr_b;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic        rd_valid;
    logic        clr;
    logic [1:0]  clr_target;
    logic        busy;
    logic        clr_done;

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_q[$];

`ifdef SP_ACC_SAT_EN
    localparam logic [63:0] OVF_EXP = 64'h80000000_7FFFFFFF;
`else
    localparam logic [63:0] OVF_EXP = 64'h7FFFFFFF_80000000;
`endif

    sp_accum_bank dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wr_en_i      (wr_en),
        .wr_acc_i     (wr_acc),
        .wr_strb_i    (wr_strb),
        .wr_target_i  (wr_target),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .wr_ready_o   (wr_ready),
        .rd_en_i      (rd_en),
        .rd_target_i  (rd_target),
        .rd_addr_a_i  (rd_addr_a),
        .rd_addr_b_i  (rd_addr_b),
        .rd_data_a_o  (rd_data_a),
        .rd_data_b_o  (rd_data_b),
        .rd_valid_o   (rd_valid),
        .clr_i        (clr),
        .clr_target_i (clr_target),
        .busy_o       (busy),
        .clr_done_o   (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // Fill pattern: distinct per target/address, hand-chosen.
    function automatic logic [63:0] fill(input int t, input int a);
        return {32'h0000_1000 + 32'(t*16 + a), 32'h0000_2000 + 32'(t*16 + a)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        wr_acc  = 1'b0;
        wr_strb = 2'b00;
        rd_en   = 1'b0;
        clr     = 1'b0;
    endtask

    task automatic set_wr(input int t, input int a, input logic [63:0] d,
                          input logic [1:0] s, input logic acc);
        wr_en     = 1'b1;
        wr_target = 2'(t);
        wr_addr   = 2'(a);
        wr_data   = d;
        wr_strb   = s;
        wr_acc    = acc;
    endtask

    task automatic set_rd(input int t, input int a, input int b,
                          input logic [63:0] ea, input logic [63:0] eb);
        rd_en     = 1'b1;
        rd_target = 2'(t);
        rd_addr_a = 2'(a);
        rd_addr_b = 2'(b);
        exp_q.push_back({ea, eb});
    endtask

    // Scoreboard monitor: one expected pair is consumed per valid beat.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got valid=1 want no read pending");
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                check("rd_a", rd_data_a, e[127:64]);
                check("rd_b", rd_data_b, e[63:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_acc = 1'b0; wr_strb = 2'b00;
        wr_target = '0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_target = '0; rd_addr_a = '0; rd_addr_b = '0;
        clr = 1'b0; clr_target = '0;

        step(); step();
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(clr_done), 64'd0);
        check("rst_ready", 64'(wr_ready), 64'd1);
        check("rst_data_a", rd_data_a, 64'd0);
        check("rst_data_b", rd_data_b, 64'd0);
        rst_n = 1'b1;

        // Every line reads zero after reset, back-to-back.
        for (int t = 0; t < 4; t++)
            for (int a = 0; a < 4; a++) begin
                set_rd(t, a, 3 - a, 64'd0, 64'd0);
                step();
            end

        // Overwrite then strobed accumulate.
        set_wr(2, 1, 64'h00000005_00000003, 2'b11, 1'b0); step();
        set_rd(2, 1, 1, 64'h00000005_00000003, 64'h00000005_00000003); step();
        set_wr(2, 1, 64'h00000001_00000002, 2'b01, 1'b1); step();
        set_rd(2, 1, 0, 64'h00000005_00000005, 64'd0); step();

        // Overflow in both directions; then a zero-strobe write is a no-op.
        set_wr(0, 2, 64'h80000000_7FFFFFFF, 2'b11, 1'b0); step();
        set_wr(0, 2, 64'hFFFFFFFF_00000001, 2'b11, 1'b1); step();
        set_rd(0, 2, 2, OVF_EXP, OVF_EXP); step();
        set_wr(0, 2, 64'hFFFFFFFF_FFFFFFFF, 2'b00, 1'b0); step();
        set_rd(0, 2, 2, OVF_EXP, OVF_EXP); step();

        // Fill targets 0 and 1.
        for (int t = 0; t < 2; t++)
            for (int a = 0; a < 4; a++) begin
                set_wr(t, a, fill(t, a), 2'b11, 1'b0);
                step();
            end

        // Start clear of target 1 with a write to target 0 on the same edge.
        set_wr(0, 1, 64'h00000055_00000066, 2'b11, 1'b0);
        clr = 1'b1; clr_target = 2'd1;
        step();
        check("clr_busy_e0", 64'(busy), 64'd1);
        check("clr_ready_e0", 64'(wr_ready), 64'd0);
        check("clr_done_e0", 64'(clr_done), 64'd0);
        for (int c = 1; c <= 3; c++) begin
            set_wr(0, 0, 64'hDEADBEEF_DEADBEEF, 2'b11, 1'b0);
            clr = 1'b1; clr_target = 2'd0;
            // Line (1,0) is already cleared here while (1,3) still holds data.
            if (c == 2) set_rd(1, 0, 3, 64'd0, fill(1, 3));
            step();
            check("clr_busy_mid", 64'(busy), 64'd1);
            check("clr_done_mid", 64'(clr_done), 64'd0);
        end
        step();
        check("clr_busy_end", 64'(busy), 64'd0);
        check("clr_done_pulse", 64'(clr_done), 64'd1);
        step();
        check("clr_done_after", 64'(clr_done), 64'd0);
        check("clr_busy_after", 64'(busy), 64'd0);

        for (int a = 0; a < 4; a++) begin
            set_rd(1, a, a, 64'd0, 64'd0);
            step();
        end
        set_rd(0, 0, 1, fill(0, 0), 64'h00000055_00000066); step();
        set_rd(0, 2, 3, fill(0, 2), fill(0, 3)); step();

        // Same-edge read and write: the read sees the old line.
        set_wr(0, 3, 64'h00000000_0000000A, 2'b11, 1'b0); step();
        set_wr(0, 3, 64'h00000000_0000000B, 2'b11, 1'b0);
        set_rd(0, 3, 0, 64'h00000000_0000000A, fill(0, 0)); step();
        set_rd(0, 3, 0, 64'h00000000_0000000B, fill(0, 0)); step();
        set_rd(0, 0, 3, fill(0, 0), 64'h00000000_0000000B); step();
        set_rd(0, 3, 3, 64'h00000000_0000000B, 64'h00000000_0000000B); step();
        step(); step();

        // Reset two cycles into a sweep of target 0.
        clr = 1'b1; clr_target = 2'd0;
        step();
        step(); step();
        rst_n = 1'b0;
        #2;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(clr_done), 64'd0);
        check("arst_valid", 64'(rd_valid), 64'd0);
        check("arst_data_a", rd_data_a, 64'd0);
        step(); step();
        rst_n = 1'b1;
        check("arst_rel_busy", 64'(busy), 64'd0);
        step();
        check("arst_no_done", 64'(clr_done), 64'd0);
        for (int t = 0; t < 4; t++)
            for (int a = 0; a < 4; a++) begin
                set_rd(t, a, a ^ 1, 64'd0, 64'd0);
                step();
            end
        step(); step();

        check("rd_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sp_accum_bank.md
Name: sp_accum_bank

Overview:
- Parametrised next-generation scratchpad for the matrix-multiply accelerator. Holds SP_NTARGETS result matrices of MAX_DIM x MAX_DIM elements; each line is one BUS_WIDTH row.
- New versus the previous scratchpad:
  - registered dual read port with a valid flag;
  - per-element write strobes;
  - element-wise accumulate writes;
  - hardware clear of one target through a sweep state machine.
- Sits between the matmul engine (write/accumulate side) and the bus/APB read-out logic.

Parameters:
- SP_NTARGETS, 4, number of addressable matrix targets (>=1, power of 2).
- DATA_WIDTH, 32, element width in bits.
- BUS_WIDTH, 64, line width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (local, power of 2, >=2).
- AW (local), 2*$clog2(MAX_DIM), line address width within a target.
- TW (local), max(1,$clog2(SP_NTARGETS)), target select width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- wr_en_i  in  1  write request.
- wr_acc_i  in  1  1 = accumulate (mem += data), 0 = overwrite.
- wr_strb_i  in  MAX_DIM  per-element enable; bit k covers bits [k*DATA_WIDTH +: DATA_WIDTH].
- wr_target_i  in  TW  write target.
- wr_addr_i  in  AW  write line address.
- wr_data_i  in  BUS_WIDTH  write data.
- wr_ready_o  out  1  write accepted when high.
- rd_en_i  in  1  read request.
- rd_target_i  in  TW  read target.
- rd_addr_a_i  in  AW  line address for port A.
- rd_addr_b_i  in  AW  line address for port B.
- rd_data_a_o  out  BUS_WIDTH  port A data.
- rd_data_b_o  out  BUS_WIDTH  port B data.
- rd_valid_o  out  1  read data valid.
- clr_i  in  1  start clear of clr_target_i.
- clr_target_i  in  TW  target to clear.
- busy_o  out  1  clear in progress.
- clr_done_o  out  1  one-cycle pulse when a clear finishes.

Behaviour:
- Reset (async, active-low):
  - all SP_NTARGETS*MAX_DIM*MAX_DIM lines = 0;
  - rd_data_a_o = rd_data_b_o = 0; rd_valid_o = 0; busy_o = 0; clr_done_o = 0; FSM = IDLE; sweep counter = 0.
  - Reset asserted mid-clear aborts the sweep; memory is zeroed anyway.
- Line index = target*MAX_DIM*MAX_DIM + addr.
- Write:
  - wr_ready_o = ~busy_o (combinational).
  - A write is accepted when wr_en_i & wr_ready_o at a rising edge; lines update on that edge.
  - wr_en_i while not ready is dropped, not queued.
  - Only elements with their strobe bit set change.
  - wr_acc_i = 0: element <= data element.
  - wr_acc_i = 1: element <= element + data element, two's complement, truncated to DATA_WIDTH (wrap).
  - wr_strb_i = 0 makes the write a no-op.
- Read:
  - rd_en_i sampled at edge N; rd_data_a_o/rd_data_b_o register the line contents before any write on edge N; rd_valid_o = 1 after edge N.
  - Latency is 1 cycle. Back-to-back reads give one result per cycle.
  - rd_en_i = 0 at an edge: rd_valid_o <= 0 and the data outputs hold their last value.
  - Reads are allowed while busy and return the current, partially cleared contents.
  - Read and write to the same line on the same edge: read returns the old value.
  - rd_addr_a_i = rd_addr_b_i is legal; both ports return the same line.
- Clear FSM:
  - IDLE: clr_i at an edge latches clr_target_i, sets cnt = 0 and moves to CLEAR; busy_o = 1 from that edge.
  - CLEAR: each edge zeroes line (tgt, cnt) and increments cnt. On the edge that writes cnt = MAX_DIM*MAX_DIM-1: go to IDLE, busy_o <= 0, clr_done_o <= 1 for one cycle.
  - A clear therefore takes MAX_DIM*MAX_DIM cycles and touches only the latched target.
  - clr_i while busy is ignored.
  - clr_i and an accepted write on the same edge: the write is performed; the sweep starts on the next edge and clears that line if it is in the cleared target.
- Out-of-range target values (SP_NTARGETS not a power of 2) are forbidden by parameter constraint.

Optional Feature:
- Macro SP_ACC_SAT_EN.
- Defined: accumulate treats elements as signed DATA_WIDTH values and saturates to the most-positive/most-negative value on overflow/underflow.
- Undefined: accumulate wraps modulo 2^DATA_WIDTH.
- Overwrite, clear and read behaviour are identical in both builds.

Test Plan:
- Reset, then read every line of every target -> all zero; rd_valid_o = 1 one cycle after each rd_en_i.
- Write target 2, addr 1, data 0x00000005_00000003, strobe 2'b11; next cycle read -> 0x00000005_00000003. Then accumulate data 0x00000001_00000002 with strobe 2'b01 -> 0x00000005_00000005.
- Write 0x7FFFFFFF into element 0, then accumulate 1 -> 0x80000000 without SP_ACC_SAT_EN; 0x7FFFFFFF with it.
- Fill targets 0 and 1, pulse clr_i with target 1 -> busy_o high for 4 cycles; wr_en_i during busy is dropped; clr_done_o pulses once; target 1 reads all zero; target 0 unchanged.
- Same-edge read and write of target 0 addr 3 (old 0xA, new 0xB) -> rd_data_a_o = 0xA; the next read = 0xB. Ports A and B reading addr 0 and addr 3 simultaneously return their respective lines.
- Assert rst_ni low mid-clear, 2 cycles into the sweep -> busy_o = 0, no clr_done_o pulse, all memory zero after release.
